calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
//
// PURPOSE
// Drives the lab calculator's button/switch interface from a queued command stream, in place of a user.
// - Host pushes (func, operand) commands into a small FIFO.
// - The block replays each command as a debounce-friendly button press: setup, press, release.
// - It captures the calculator's LED result and returns it to the host over a valid/ready channel.
// - It sits between a host (UART/bus/test controller) and the calc's btnl/btnc/btnr/btnd/btnu/sw/led pins.
//
// PARAMETERS
// DEPTH          4   command FIFO entries (power of two, >=2)
// SETUP_CYCLES   2   cycles func/sw are stable with op low before the press (>=1)
// PRESS_CYCLES   4   cycles calc_op is held high (>=1)
// RELEASE_CYCLES 4   cycles op is held low after the press before the result is sampled (>=1)
//
// PORTS
// clk          in   1   system clock
// rst_n        in   1   asynchronous, active-low reset
// cmd_valid    in   1   host command valid
// cmd_ready    out  1   FIFO not full; a push occurs when cmd_valid & cmd_ready
// cmd_func     in   3   000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed-lt; 110/111 are passed through
// cmd_operand  in   16  operand presented on calc_sw
// clear        in   1   one-cycle request to reset the calculator accumulator
// calc_func    out  3   to {btnl,btnc,btnr}
// calc_sw      out  16  to sw
// calc_op      out  1   to btnd (execute button)
// calc_rst     out  1   to btnu, active high
// calc_result  in   16  from led
// res_valid    out  1   result available
// res_ready    in   1   host accepts the result
// res_data     out  16  sampled calc_result
// res_func     out  3   func of the command that produced res_data
// busy         out  1   state != IDLE or FIFO non-empty or clear pending
// count        out  $clog2(DEPTH+1)  FIFO occupancy
//
// BEHAVIOUR
// - Clocking and reset: one clock; reset is asynchronous and active-low.
// - While rst_n=0, all outputs are 0 except cmd_ready=1. The FIFO is empty, the state is IDLE and clear_pending=0.
// - An async reset mid-operation drops calc_op/calc_rst immediately. Any queued or in-flight command is discarded.
// - FIFO:
//   - cmd_ready = (count < DEPTH), computed from the registered count. There is no same-cycle pass-through when full.
//   - A push and a pop in the same cycle leave count unchanged.
// - clear is latched into clear_pending in any state. It is serviced on the next IDLE, ahead of FIFO commands.
//   - A clear that arrives while clear_pending=1 merges with the pending one.
//   - A clear does not flush the FIFO.
// - State machine (registered outputs, counter cnt):
//   - IDLE:
//     - If clear_pending, go to CLEAR.
//     - Else if the FIFO is non-empty, pop the head into the calc_func/calc_sw registers and go to SETUP.
//   - SETUP (SETUP_CYCLES): calc_op=0, func/sw stable. Then go to PRESS.
//   - PRESS (PRESS_CYCLES): calc_op=1. Then go to RELEASE.
//   - RELEASE (RELEASE_CYCLES): calc_op=0.
//     - On its last cycle, register calc_result into res_data and func into res_func.
//     - Then go to REPORT.
//   - REPORT: res_valid=1, res_data/res_func stable.
//     - On res_valid & res_ready, clear res_valid and go to IDLE.
//     - The next command cannot start in the same cycle.
//   - CLEAR: calc_rst=1 for exactly 2 cycles, clear_pending<=0, then go to IDLE. No result is reported.
// - calc_func and calc_sw hold their last values outside SETUP/PRESS/RELEASE and never change while calc_op=1.
// - Latency: the head command is popped at edge T.
//   - calc_op rises at T+SETUP_CYCLES.
//   - res_valid rises at T+SETUP_CYCLES+PRESS_CYCLES+RELEASE_CYCLES.
// - calc_op is exactly one contiguous high pulse per command, so the calculator's rising-edge detect fires once.
// - The block performs no arithmetic. res_data is whatever the calculator shows (16-bit wrap is the calculator's).
//
// TESTING
// - Reset then clear, push ADD 0x0005 -> calc_rst high 2 cycles, one calc_op pulse of 4 cycles, res_data=0x0005, res_func=000.
// - Then SUB 0x0007 -> res_data=0xFFFE. Then LT 0x0001 (signed -2<1) -> res_data=0x0001.
// - Push 5 commands back-to-back while the first runs -> cmd_ready=0 after the 4th queued entry.
//   - The 5th is held until a pop; all 5 results are returned in order.
// - Hold res_ready=0 for 20 cycles in REPORT -> res_valid/res_data stable, calc_op stays 0, count unchanged.
// - Pulse clear during PRESS -> current result still reported, then CLEAR runs before the next queued command.
// - Drop rst_n during PRESS -> calc_op=0 within the same cycle, count=0, res_valid=0, cmd_ready=1.
// - Scoreboard: a reference accumulator over random func/operand streams matches res_data for 200 commands.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Replays queued (func, operand) commands on the lab calculator's button/switch pins as
// setup/press/release sequences and hands the sampled LED value back to the host.
module calc_op_sequencer #(
    parameter int DEPTH          = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int PRESS_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [2:0]                   i_cmd_func,
    input  logic [15:0]                  i_cmd_operand,
    input  logic                         i_clear,
    output logic [2:0]                   o_calc_func,
    output logic [15:0]                  o_calc_sw,
    output logic                         o_calc_op,
    output logic                         o_calc_rst,
    input  logic [15:0]                  i_calc_result,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [15:0]                  o_res_data,
    output logic [2:0]                   o_res_func,
    output logic                         o_busy,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int MAX_SP = (SETUP_CYCLES > PRESS_CYCLES) ? SETUP_CYCLES : PRESS_CYCLES;
    localparam int MAX_SR = (MAX_SP > RELEASE_CYCLES) ? MAX_SP : RELEASE_CYCLES;
    // CLEAR also runs off the phase timer and needs to reach 1
    localparam int MAX_CY = (MAX_SR > 2) ? MAX_SR : 2;
    localparam int TMR_W  = $clog2(MAX_CY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PRESS,
        S_RELEASE,
        S_REPORT,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_cnt;
    logic               r_clear_pending;
    logic [2:0]         r_calc_func;
    logic [15:0]        r_calc_sw;
    logic               r_calc_op;
    logic               r_calc_rst;
    logic               r_res_valid;
    logic [15:0]        r_res_data;
    logic [2:0]         r_res_func;

    logic [18:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [18:0]        w_head;

    assign o_cmd_ready = (r_count < CNT_W'(DEPTH));
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_pop       = (r_state == S_IDLE) && !r_clear_pending && (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_func, i_cmd_operand};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_clear_pending <= 1'b0;
            r_calc_func     <= '0;
            r_calc_sw       <= '0;
            r_calc_op       <= 1'b0;
            r_calc_rst      <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_data      <= '0;
            r_res_func      <= '0;
        end else begin
            // A clear arriving on the last CLEAR cycle is absorbed by the one being serviced
            if (i_clear) r_clear_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (r_clear_pending) begin
                        r_calc_rst <= 1'b1;
                        r_state    <= S_CLEAR;
                    end else if (w_pop) begin
                        r_calc_func <= w_head[18:16];
                        r_calc_sw   <= w_head[15:0];
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == TMR_W'(SETUP_CYCLES - 1)) begin
                        r_cnt     <= '0;
                        r_calc_op <= 1'b1;
                        r_state   <= S_PRESS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PRESS: begin
                    if (r_cnt == TMR_W'(PRESS_CYCLES - 1)) begin
                        r_cnt     <= '0;
                        r_calc_op <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == TMR_W'(RELEASE_CYCLES - 1)) begin
                        r_cnt       <= '0;
                        r_res_data  <= i_calc_result;
                        r_res_func  <= r_calc_func;
                        r_res_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == TMR_W'(1)) begin
                        r_cnt           <= '0;
                        r_calc_rst      <= 1'b0;
                        r_clear_pending <= 1'b0;
                        r_state         <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_calc_func = r_calc_func;
    assign o_calc_sw   = r_calc_sw;
    assign o_calc_op   = r_calc_op;
    assign o_calc_rst  = r_calc_rst;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_func  = r_res_func;
    assign o_count     = r_count;
    assign o_busy      = (r_state != S_IDLE) || (r_count != '0) || r_clear_pending;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: emulates the calculator behind the pins and scores every
// returned result against an accumulator model fed from the host-side command stream.
module tb_calc_op_sequencer;

    localparam int DEPTH   = 4;
    localparam int SETUP   = 2;
    localparam int PRESS   = 4;
    localparam int RELEASE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_func = '0;
    logic [15:0] cmd_operand = '0;
    logic        clear = 1'b0;
    logic [2:0]  calc_func;
    logic [15:0] calc_sw;
    logic        calc_op;
    logic        calc_rst;
    logic [15:0] calc_result;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [2:0]  res_func;
    logic        busy;
    logic [2:0]  count;

    always #5 clk = ~clk;

    calc_op_sequencer #(
        .DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .PRESS_CYCLES(PRESS), .RELEASE_CYCLES(RELEASE)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_func(cmd_func), .i_cmd_operand(cmd_operand), .i_clear(clear),
        .o_calc_func(calc_func), .o_calc_sw(calc_sw), .o_calc_op(calc_op), .o_calc_rst(calc_rst),
        .i_calc_result(calc_result),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_func(res_func),
        .o_busy(busy), .o_count(count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] calc_f(input logic [15:0] a, input logic [2:0] f,
                                           input logic [15:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return a;
        endcase
    endfunction

    // Calculator stand-in: acts once per rising edge of the execute button
    logic [15:0] acc_hw = '0;
    logic        op_prev = 1'b0;
    always @(posedge clk) begin
        op_prev <= calc_op;
        if (calc_rst) acc_hw <= '0;
        else if (calc_op && !op_prev) acc_hw <= calc_f(acc_hw, calc_func, calc_sw);
    end
    assign calc_result = acc_hw;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  func;
        logic [15:0] data;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] ref_acc = '0;
    int          n_pushed = 0;
    int          n_clears = 0;

    // Host-side result consumer
    bit          hold_ready = 1'b0;
    bit          rand_ready = 1'b0;
    int          n_results = 0;
    logic [15:0] last_data = '0;
    logic [2:0]  last_func = '0;
    initial begin : consumer
        bit   r;
        res_t e;
        forever begin
            @(negedge clk);
            r = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rst_n && res_valid && r) begin
                n_results++;
                last_data = res_data;
                last_func = res_func;
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("RES #%0d func=%0d data=0x%04h exp_func=%0d exp_data=0x%04h",
                             n_results, res_func, res_data, e.func, e.data);
                    check("res_data", res_data, e.data);
                    check("res_func", res_func, e.func);
                end
            end
            res_ready = r;
        end
    end

    // Pin monitor: press width, operand stability, calc_rst width, rise times
    int   op_len = 0, rst_len = 0, n_op_pulses = 0, n_rst_pulses = 0;
    int   op_rise_cyc = 0, rst_rise_cyc = 0, valid_rise_cyc = 0;
    bit   sw_moved = 1'b0, valid_prev = 1'b0;
    logic [18:0] op_snap = '0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                op_len = 0; rst_len = 0; sw_moved = 1'b0; valid_prev = 1'b0;
            end else begin
                if (calc_op) begin
                    if (op_len == 0) begin
                        op_rise_cyc = cyc;
                        op_snap = {calc_func, calc_sw};
                    end else if ({calc_func, calc_sw} != op_snap) begin
                        sw_moved = 1'b1;
                    end
                    op_len++;
                end else if (op_len != 0) begin
                    check("op_width", op_len, PRESS);
                    check("op_sw_stable", sw_moved, 0);
                    n_op_pulses++;
                    op_len = 0;
                    sw_moved = 1'b0;
                end
                if (calc_rst) begin
                    if (rst_len == 0) rst_rise_cyc = cyc;
                    rst_len++;
                end else if (rst_len != 0) begin
                    check("rst_width", rst_len, 2);
                    n_rst_pulses++;
                    rst_len = 0;
                end
                if (res_valid && !valid_prev) valid_rise_cyc = cyc;
                valid_prev = res_valid;
            end
        end
    end

    task automatic push(input logic [2:0] f, input logic [15:0] d, input bit zero_first,
                        output int acc_cyc, output int waited);
        cmd_valid = 1'b1; cmd_func = f; cmd_operand = d; waited = 0;
        while (!cmd_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("push_accept", cmd_ready, 1);
        @(negedge clk);
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        n_pushed++;
        if (zero_first) ref_acc = '0;
        ref_acc = calc_f(ref_acc, f, d);
        exp_q.push_back({f, ref_acc});
    endtask

    task automatic push_s(input logic [2:0] f, input logic [15:0] d);
        int a, w;
        push(f, d, 1'b0, a, w);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_clears++;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, (exp_q.size() != 0 || busy), 0);
        @(negedge clk);
    endtask

    task automatic wait_op_high(input string tag);
        int n = 0;
        while (!calc_op && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, calc_op, 1);
    endtask

    initial begin : main
        int a_cyc, w, rst_base, n;
        logic [2:0]  f;
        logic [15:0] d;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_calc_op", calc_op, 0);
        check("rst_calc_rst", calc_rst, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_calc_func", calc_func, 0);
        check("rst_calc_sw", calc_sw, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_func", res_func, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // clear, then ADD / SUB / signed-LT with latency measurement on the first
        pulse_clear();
        ref_acc = '0;
        wait_drain("drain_clear");
        check("clear_rst_pulses", n_rst_pulses, 1);
        push(3'd0, 16'h0005, 1'b0, a_cyc, w);
        wait_drain("drain_add");
        check("add_lat_op", op_rise_cyc - a_cyc, SETUP + 1);
        check("add_lat_res", valid_rise_cyc - a_cyc, SETUP + PRESS + RELEASE + 1);
        check("add_data", last_data, 16'h0005);
        check("add_func", last_func, 3'd0);
        push_s(3'd1, 16'h0007);
        wait_drain("drain_sub");
        check("sub_data", last_data, 16'hFFFE);
        push_s(3'd5, 16'h0001);
        wait_drain("drain_lt");
        check("lt_data", last_data, 16'h0001);
        check("lt_func", last_func, 3'd5);

        // one running plus five queued: the FIFO fills after four, the fifth waits for a pop
        n = n_results;
        push_s(3'd0, 16'h0100);
        for (int k = 0; k < 4; k++) push_s(3'(k % 5), 16'(16'h0011 * (k + 1)));
        check("full_count", count, DEPTH);
        check("full_ready", cmd_ready, 0);
        push(3'd3, 16'h00F0, 1'b0, a_cyc, w);
        check("fifth_held", (w > 0), 1);
        wait_drain("drain_b2b");
        check("b2b_results", n_results - n, 6);

        // host stalls the result for 20 cycles with one command still queued
        hold_ready = 1'b1;
        push_s(3'd0, 16'h0010);
        push_s(3'd4, 16'h00FF);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", res_valid, 1);
        for (int k = 0; k < 20; k++) begin
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp_q[0].data);
            check("hold_op", calc_op, 0);
            check("hold_count", count, 1);
            @(negedge clk);
        end
        hold_ready = 1'b0;
        wait_drain("drain_hold");

        // clear during PRESS: current result still reported, CLEAR precedes the queued one
        rst_base = n_rst_pulses;
        push_s(3'd0, 16'h1234);
        push(3'd0, 16'h0011, 1'b1, a_cyc, w);
        wait_op_high("clr_wait_op");
        pulse_clear();
        wait_drain("drain_clr_press");
        check("clr_press_rst_pulses", n_rst_pulses - rst_base, 1);
        check("clr_before_next", (rst_rise_cyc < op_rise_cyc), 1);
        check("clr_next_data", last_data, 16'h0011);

        // asynchronous reset in the middle of a press
        push_s(3'd0, 16'h0042);
        push_s(3'd1, 16'h0001);
        wait_op_high("rst_wait_op");
        rst_n = 1'b0;
        #1;
        check("arst_calc_op", calc_op, 0);
        check("arst_count", count, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_calc_rst", calc_rst, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        n_pushed -= 2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_clear();
        ref_acc = '0;
        wait_drain("drain_after_arst");

        // randomized stream with random host stalls and periodic clears
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            f = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
            push_s(f, d);
            if (i % 50 == 49) begin
                wait_drain("drain_rand_blk");
                pulse_clear();
                ref_acc = '0;
                wait_drain("drain_rand_clr");
            end
        end
        rand_ready = 1'b0;
        wait_drain("drain_rand");

        check("total_results", n_results, n_pushed);
        check("total_op_pulses", n_op_pulses, n_results);
        check("total_rst_pulses", n_rst_pulses, n_clears);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
